// File: rtl/sw_array_ctrl_if.sv
// Host/DMA stream bundle for the Smith-Waterman array controller.
//   q_valid/q_ready/q_data          : query bases, one per PE, in PE order
//   t_valid/t_ready/t_data/t_last   : target bases streamed through the array
// Base encoding on both streams: A=00, G=01, T=10, C=11.
// master = stream source (host/DMA), slave = sw_array_ctrl.
interface sw_array_ctrl_if;
    logic       q_valid;
    logic       q_ready;
    logic [1:0] q_data;
    logic       t_valid;
    logic       t_ready;
    logic [1:0] t_data;
    logic       t_last;

    modport master (
        output q_valid, q_data, t_valid, t_data, t_last,
        input  q_ready, t_ready
    );

    modport slave (
        input  q_valid, q_data, t_valid, t_data, t_last,
        output q_ready, t_ready
    );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencing controller for the Smith-Waterman systolic PE array.
// One job: clear the PEs, preload N_PE query bases (one per cycle, PE 0 first),
// stream the target through the leftmost PE in a gap-free enable window,
// drain the chain while tracking the peak score leaving the rightmost PE,
// then report one result.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start, local_mode job start pulse (IDLE only) and alignment mode
//   bus               query/target stream handshakes (slave side)
//   pe_rst, pe_local  PE reset and local/global select, broadcast to all PEs
//   pe_ld_we/addr/data  query preload port (addr 0 = leftmost PE)
//   pe_en, pe_data    enable and target base into the leftmost PE
//   arr_en, arr_high  o_en / o_high of the rightmost PE
//   busy              high whenever not IDLE
//   res_valid/score/err  one-cycle result strobe, peak (offset-binary), error
module sw_array_ctrl #(
    parameter int N_PE        = 48,
    parameter int LOG_N       = 6,
    parameter int SCORE_WIDTH = 11,
    parameter int LOG_TLEN    = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   local_mode,
    sw_array_ctrl_if.slave         bus,
    output logic                   pe_rst,
    output logic                   pe_local,
    output logic                   pe_ld_we,
    output logic [LOG_N-1:0]       pe_ld_addr,
    output logic [1:0]             pe_ld_data,
    output logic                   pe_en,
    output logic [1:0]             pe_data,
    input  logic                   arr_en,
    input  logic [SCORE_WIDTH-1:0] arr_high,
    output logic                   busy,
    output logic                   res_valid,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic                   res_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    // Score zero in offset-binary representation.
    localparam logic [SCORE_WIDTH-1:0] SCORE_ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
    localparam logic [LOG_N-1:0]       LAST_IDX   = LOG_N'(N_PE - 1);
    // DRAIN lasts at most N_PE+3 cycles, so result lands N_PE+4 cycles after
    // the final target transfer when the array never reports.
    localparam logic [LOG_N-1:0]       DRAIN_LAST = LOG_N'(N_PE + 2);
    localparam logic [LOG_TLEN-1:0]    TLEN_MAX   = '1;

    // Offset-binary scores order correctly under an unsigned compare.
    function automatic logic [SCORE_WIDTH-1:0] score_max(
        input logic [SCORE_WIDTH-1:0] a,
        input logic [SCORE_WIDTH-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    state_t                 state_q, state_d;
    logic [LOG_N-1:0]       cnt_q, cnt_d;
    logic [LOG_TLEN-1:0]    tlen_q, tlen_d;
    logic [SCORE_WIDTH-1:0] peak_q, peak_d;
    logic                   err_q, err_d;
    logic                   seen_q, seen_d;
    logic                   pe_rst_q, pe_rst_d;
    logic                   pe_local_q, pe_local_d;
    logic                   ld_we_q, ld_we_d;
    logic [LOG_N-1:0]       ld_addr_q, ld_addr_d;
    logic [1:0]             ld_data_q, ld_data_d;
    logic                   pe_en_q, pe_en_d;
    logic [1:0]             pe_data_q, pe_data_d;
    logic                   busy_q, busy_d;
    logic                   res_valid_q, res_valid_d;
    logic [SCORE_WIDTH-1:0] res_score_q, res_score_d;
    logic                   res_err_q, res_err_d;
    logic                   q_hs, t_hs;

    // Ready lines are decoded straight from state so t_ready can only rise
    // once STREAM is entered, never on the cycle of the last query write.
    assign bus.q_ready = (state_q == S_LOAD);
    assign bus.t_ready = (state_q == S_STREAM);

    assign q_hs = bus.q_valid && (state_q == S_LOAD);
    assign t_hs = bus.t_valid && (state_q == S_STREAM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tlen_d      = tlen_q;
        peak_d      = peak_q;
        err_d       = err_q;
        seen_d      = seen_q;
        pe_local_d  = pe_local_q;
        ld_we_d     = 1'b0;
        ld_addr_d   = ld_addr_q;
        ld_data_d   = ld_data_q;
        pe_en_d     = 1'b0;
        pe_data_d   = 2'b00;
        res_score_d = res_score_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pe_local_d = local_mode;
                    cnt_d      = '0;
                    tlen_d     = '0;
                    peak_d     = SCORE_ZERO;
                    err_d      = 1'b0;
                    seen_d     = 1'b0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LOG_N'(1)) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + LOG_N'(1);
                end
            end
            S_LOAD: begin
                if (q_hs) begin
                    ld_we_d   = 1'b1;
                    ld_addr_d = cnt_q;
                    ld_data_d = bus.q_data;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d = cnt_q + LOG_N'(1);
                    end
                end
            end
            S_STREAM: begin
                if (t_hs) begin
                    if (tlen_q == TLEN_MAX) begin
                        // Target too long: this base is dropped, window closes.
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        pe_en_d   = 1'b1;
                        pe_data_d = bus.t_data;
                        tlen_d    = tlen_q + LOG_TLEN'(1);
                        if (bus.t_last) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else if (tlen_q != '0) begin
                    // A gap would reinitialise the PEs mid-alignment.
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (seen_q && !arr_en) begin
                    state_d = S_RESULT;
                end else if (cnt_q == DRAIN_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    cnt_d = cnt_q + LOG_N'(1);
                end
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_STREAM || state_q == S_DRAIN) && arr_en) begin
            peak_d = score_max(peak_q, arr_high);
            seen_d = 1'b1;
        end

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        pe_rst_d    = (state_d == S_CLEAR);
        busy_d      = (state_d != S_IDLE);
        res_valid_d = (state_d == S_RESULT);
        res_err_d   = res_valid_d && err_d;
        if (res_valid_d) begin
            res_score_d = peak_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tlen_q      <= '0;
            peak_q      <= SCORE_ZERO;
            err_q       <= 1'b0;
            seen_q      <= 1'b0;
            pe_rst_q    <= 1'b1;
            pe_local_q  <= 1'b0;
            ld_we_q     <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= 2'b00;
            pe_en_q     <= 1'b0;
            pe_data_q   <= 2'b00;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_score_q <= SCORE_ZERO;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tlen_q      <= tlen_d;
            peak_q      <= peak_d;
            err_q       <= err_d;
            seen_q      <= seen_d;
            pe_rst_q    <= pe_rst_d;
            pe_local_q  <= pe_local_d;
            ld_we_q     <= ld_we_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            pe_en_q     <= pe_en_d;
            pe_data_q   <= pe_data_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_score_q <= res_score_d;
            res_err_q   <= res_err_d;
        end
    end

    assign pe_rst     = pe_rst_q;
    assign pe_local   = pe_local_q;
    assign pe_ld_we   = ld_we_q;
    assign pe_ld_addr = ld_addr_q;
    assign pe_ld_data = ld_data_q;
    assign pe_en      = pe_en_q;
    assign pe_data    = pe_data_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_score  = res_score_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Testbench for sw_array_ctrl: directed scenarios plus randomized jobs.
// The rightmost-PE behaviour is emulated as a pure delay of pe_en carrying a
// queue of score values; expected results come from job-level rules.
`timescale 1ns/1ps
module tb_sw_array_ctrl;
    localparam int N_PE     = 4;
    localparam int LOG_N    = 4;
    localparam int SW       = 11;
    localparam int LOG_TLEN = 4;
    localparam int TLEN_MAX = (1 << LOG_TLEN) - 1;
    localparam logic [SW-1:0] ZERO = SW'(1 << (SW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic local_mode = 1'b0;
    logic pe_rst, pe_local, pe_ld_we, pe_en, busy, res_valid, res_err;
    logic [LOG_N-1:0] pe_ld_addr;
    logic [1:0] pe_ld_data, pe_data;
    logic arr_en;
    logic [SW-1:0] arr_high, res_score;

    sw_array_ctrl_if bus_if();

    sw_array_ctrl #(.N_PE(N_PE), .LOG_N(LOG_N), .SCORE_WIDTH(SW), .LOG_TLEN(LOG_TLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .local_mode(local_mode), .bus(bus_if),
        .pe_rst(pe_rst), .pe_local(pe_local), .pe_ld_we(pe_ld_we), .pe_ld_addr(pe_ld_addr),
        .pe_ld_data(pe_ld_data), .pe_en(pe_en), .pe_data(pe_data), .arr_en(arr_en),
        .arr_high(arr_high), .busy(busy), .res_valid(res_valid), .res_score(res_score),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    int cyc = 0;
    int ld_cnt, ld_addr_bad, ld_hold_bad, ld_first_cyc, ld_last_cyc;
    int en_cnt, en_rise, pe_data_bad, rst_cyc_cnt;
    int res_cnt, res_cyc;
    logic [1:0] ld_seen[$];
    logic [1:0] en_seen[$];
    logic en_prev = 1'b0;
    logic [SW-1:0] res_score_seen;
    logic res_err_seen;
    // Array emulation
    logic [N_PE-1:0] en_sr = '0;
    logic tie0 = 1'b0;
    logic [SW-1:0] hi_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            en_sr   = '0;
            arr_en  = 1'b0;
            en_prev = 1'b0;
        end else begin
            if (pe_rst) rst_cyc_cnt++;
            if (pe_ld_we) begin
                if (pe_ld_addr != LOG_N'(ld_cnt)) ld_addr_bad++;
                if (ld_cnt == 0) ld_first_cyc = cyc;
                ld_last_cyc = cyc;
                ld_seen.push_back(pe_ld_data);
                ld_cnt++;
            end else if (ld_cnt > 0 && ld_cnt < N_PE && pe_ld_addr != LOG_N'(ld_cnt - 1)) begin
                ld_hold_bad++;
            end
            if (pe_en) begin
                en_cnt++;
                if (!en_prev) en_rise++;
                en_seen.push_back(pe_data);
            end else if (pe_data != 2'b00) begin
                pe_data_bad++;
            end
            en_prev = pe_en;
            if (res_valid) begin
                res_cnt++;
                res_cyc = cyc;
                res_score_seen = res_score;
                res_err_seen = res_err;
            end
            arr_en = !tie0 && en_sr[N_PE-1];
            arr_high = ZERO;
            if (arr_en && hi_q.size() > 0) arr_high = hi_q.pop_front();
            en_sr = {en_sr[N_PE-2:0], pe_en};
        end
    end

    task automatic clear_mon();
        ld_cnt = 0; ld_addr_bad = 0; ld_hold_bad = 0; ld_first_cyc = 0; ld_last_cyc = 0;
        en_cnt = 0; en_rise = 0; pe_data_bad = 0; rst_cyc_cnt = 0;
        res_cnt = 0; res_cyc = 0;
        ld_seen.delete(); en_seen.delete(); hi_q.delete();
    endtask

    // Advance until the presented transfer is accepted; ok=0 on timeout.
    task automatic wait_hs(input bit is_q, output bit ok);
        int guard;
        logic rdy;
        guard = 0;
        ok = 1'b1;
        while (1) begin
            rdy = is_q ? bus_if.q_ready : bus_if.t_ready;
            @(posedge clk); #1;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_start(input logic lm);
        start = 1'b1; local_mode = lm;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_query(input logic [1:0] q[$], input int stall_after, input int stall_len,
                              input bit load_start, input string name);
        bit ok;
        for (int i = 0; i < q.size(); i++) begin
            if (i == stall_after) begin
                bus_if.q_valid = 1'b0;
                repeat (stall_len) begin @(posedge clk); #1; end
            end
            bus_if.q_valid = 1'b1;
            bus_if.q_data = q[i];
            if (load_start && i == 1) start = 1'b1;
            wait_hs(1'b1, ok);
            start = 1'b0;
            if (!ok) begin check({name, " q_hs_timeout"}, 0, 1); break; end
        end
        bus_if.q_valid = 1'b0;
        bus_if.q_data = 2'b00;
    endtask

    task automatic run_job(input string name, input logic lm, input logic [1:0] q[$],
                           input logic [1:0] t[$], input logic [SW-1:0] hi[$], input bit has_last,
                           input int stall_after, input int stall_len, input int bubble_after,
                           input bit tie, input bit load_start);
        int n_en, bad, guard, tlast_cyc;
        bit ok, exp_err;
        logic [SW-1:0] exp_score;
        // Reference: which bases enter the array, error status and peak.
        n_en = t.size();
        if (bubble_after >= 0) n_en = bubble_after;
        else if (n_en > TLEN_MAX) n_en = TLEN_MAX;
        exp_err = (bubble_after >= 0) || (t.size() > TLEN_MAX) || tie;
        exp_score = ZERO;
        if (!tie) for (int k = 0; k < n_en; k++) if (hi[k] > exp_score) exp_score = hi[k];

        clear_mon();
        tie0 = tie;
        foreach (hi[k]) hi_q.push_back(hi[k]);
        tlast_cyc = 0;
        do_start(lm);
        check({name, " pe_rst_after_start"}, 32'(pe_rst), 1);
        check({name, " busy_after_start"}, 32'(busy), 1);
        send_query(q, stall_after, stall_len, load_start, name);
        for (int i = 0; i < t.size(); i++) begin
            if (i == bubble_after) begin
                bus_if.t_valid = 1'b0;
                @(posedge clk); #1;
                break;
            end
            bus_if.t_valid = 1'b1;
            bus_if.t_data = t[i];
            bus_if.t_last = has_last && (i == t.size() - 1);
            wait_hs(1'b0, ok);
            if (!ok) begin check({name, " t_hs_timeout"}, 0, 1); break; end
            tlast_cyc = cyc;
        end
        bus_if.t_valid = 1'b0; bus_if.t_last = 1'b0; bus_if.t_data = 2'b00;
        guard = 0;
        while (res_cnt == 0 && guard < 300) begin @(posedge clk); #1; guard++; end
        check({name, " busy_after_result"}, 32'(busy), 0);
        repeat (N_PE + 6) begin @(posedge clk); #1; end

        check({name, " res_count"}, res_cnt, 1);
        check({name, " res_score"}, 32'(res_score_seen), 32'(exp_score));
        check({name, " res_err"}, 32'(res_err_seen), 32'(exp_err));
        check({name, " res_score_held"}, 32'(res_score), 32'(exp_score));
        check({name, " pe_rst_cycles"}, rst_cyc_cnt, 2);
        check({name, " pe_local"}, 32'(pe_local), 32'(lm));
        check({name, " ld_count"}, ld_cnt, N_PE);
        check({name, " ld_addr_order"}, ld_addr_bad, 0);
        check({name, " ld_addr_hold"}, ld_hold_bad, 0);
        bad = 0;
        for (int k = 0; k < N_PE; k++) if (k >= ld_seen.size() || ld_seen[k] != q[k]) bad++;
        check({name, " ld_data"}, bad, 0);
        if (stall_len == 0) check({name, " ld_consecutive"}, ld_last_cyc - ld_first_cyc, N_PE - 1);
        check({name, " en_count"}, en_cnt, n_en);
        check({name, " en_windows"}, en_rise, (n_en > 0) ? 1 : 0);
        bad = 0;
        for (int k = 0; k < n_en; k++) if (k >= en_seen.size() || en_seen[k] != t[k]) bad++;
        check({name, " en_data"}, bad, 0);
        check({name, " pe_data_idle_zero"}, pe_data_bad, 0);
        if (tie) check({name, " timeout_latency"}, res_cyc - tlast_cyc, N_PE + 4);
        tie0 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " pe_rst"}, 32'(pe_rst), 1);
        check({name, " outs_zero"}, 32'({pe_local, pe_ld_we, pe_ld_addr, pe_ld_data, pe_en, pe_data,
                                          busy, res_valid, res_err, bus_if.q_ready, bus_if.t_ready}), 0);
        check({name, " res_score"}, 32'(res_score), 32'(ZERO));
    endtask

    logic [1:0] q_agtc[$];
    logic [1:0] t_q[$];
    logic [SW-1:0] hi_v[$];

    initial begin
        bus_if.q_valid = 1'b0; bus_if.q_data = 2'b00;
        bus_if.t_valid = 1'b0; bus_if.t_data = 2'b00; bus_if.t_last = 1'b0;
        arr_en = 1'b0; arr_high = ZERO;
        clear_mon();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release pe_rst", 32'(pe_rst), 0);

        q_agtc = '{2'b00, 2'b01, 2'b10, 2'b11};
        hi_v = '{11'h405, 11'h40A, 11'h40F, 11'h414};
        run_job("happy", 1'b1, q_agtc, q_agtc, hi_v, 1'b1, -1, 0, -1, 1'b0, 1'b0);
        run_job("qstall", 1'b1, q_agtc, q_agtc, hi_v, 1'b1, 2, 3, -1, 1'b0, 1'b0);
        run_job("bubble", 1'b0, q_agtc, q_agtc, hi_v, 1'b0, -1, 0, 2, 1'b0, 1'b0);

        // Reset in the middle of STREAM.
        clear_mon();
        do_start(1'b1);
        send_query(q_agtc, -1, 0, 1'b0, "midrst");
        for (int i = 0; i < 2; i++) begin
            bit ok;
            bus_if.t_valid = 1'b1; bus_if.t_data = q_agtc[i]; bus_if.t_last = 1'b0;
            wait_hs(1'b0, ok);
            if (!ok) check("midrst t_hs_timeout", 0, 1);
        end
        bus_if.t_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (N_PE + 10) begin @(posedge clk); #1; end
        check("midrst no_result", res_cnt, 0);
        check("midrst idle", 32'(busy), 0);
        run_job("after_rst", 1'b0, q_agtc, q_agtc, hi_v, 1'b1, -1, 0, -1, 1'b0, 1'b0);

        run_job("timeout", 1'b1, q_agtc, q_agtc, hi_v, 1'b1, -1, 0, -1, 1'b1, 1'b0);
        run_job("ign_start", 1'b1, q_agtc, q_agtc, hi_v, 1'b1, -1, 0, -1, 1'b0, 1'b1);

        // Over-length target with no t_last.
        t_q.delete(); hi_v.delete();
        for (int k = 0; k < TLEN_MAX + 1; k++) begin
            t_q.push_back(2'($urandom_range(0, 3)));
            hi_v.push_back(SW'($urandom_range(32'h3C0, 32'h47F)));
        end
        run_job("overflow", 1'b0, q_agtc, t_q, hi_v, 1'b0, -1, 0, -1, 1'b0, 1'b0);

        for (int j = 0; j < 8; j++) begin
            logic [1:0] rq[$];
            int tl;
            rq.delete(); t_q.delete(); hi_v.delete();
            for (int k = 0; k < N_PE; k++) rq.push_back(2'($urandom_range(0, 3)));
            tl = $urandom_range(1, 12);
            for (int k = 0; k < tl; k++) begin
                t_q.push_back(2'($urandom_range(0, 3)));
                hi_v.push_back(SW'($urandom_range(32'h3C0, 32'h47F)));
            end
            run_job($sformatf("rand%0d", j), 1'($urandom_range(0, 1)), rq, t_q, hi_v, 1'b1,
                    $urandom_range(0, N_PE - 1), $urandom_range(0, 3), -1, 1'b0,
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
